// File: rtl/prog_fetch.sv
// Program store and fetch sequencer: 16x8 program RAM feeding the instruction decoder, PC stepped by decoder JMP/HLT.
// INSTR is a zero-latency read of RAM[PC]; the write port is ready in LOAD/HALT and stalled (PRG_READY=0) while running.
module prog_fetch #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              PRG_VALID,
  output logic              PRG_READY,
  input  logic [ADDR_W-1:0] PRG_ADDR,
  input  logic [DATA_W-1:0] PRG_DATA,
  input  logic              START,
  input  logic              JMP,
  input  logic [3:0]        IM,
  input  logic              HLT,
  output logic [DATA_W-1:0] INSTR,
  output logic [ADDR_W-1:0] PC,
  output logic              RUNNING,
  output logic              HALTED,
  output logic [CNT_W-1:0]  ICOUNT
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]    icnt_q, icnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                prg_we;

  assign PRG_READY = (state_q != S_RUN);
  assign prg_we    = PRG_VALID & PRG_READY;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    icnt_d  = icnt_q;
    case (state_q)
      S_LOAD, S_HALT: begin
        if (START) begin
          state_d = S_RUN;
          pc_d    = '0;
          icnt_d  = '0;
        end
      end
      S_RUN: begin
        // Every RUN edge retires one instruction, including the halting one.
        if (icnt_q != {CNT_W{1'b1}}) begin
          icnt_d = icnt_q + CNT_W'(1);
        end
        if (HLT) begin
          state_d = S_HALT;
        end else if (JMP) begin
          pc_d = ADDR_W'(IM);
        end else begin
          pc_d = pc_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_LOAD;
      pc_q    <= '0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      icnt_q  <= icnt_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (prg_we) begin
      mem_q[PRG_ADDR] <= PRG_DATA;
    end
  end

  assign INSTR   = mem_q[pc_q];
  assign PC      = pc_q;
  assign ICOUNT  = icnt_q;
  assign RUNNING = (state_q == S_RUN);
  assign HALTED  = (state_q == S_HALT);

endmodule
